pwl_act_pipe: RTL and testbench

- Pipelined piecewise-linear activation unit for the detection datapath. Generalises the fixed tanh slope/intercept lookup.
- Coefficients live in a run-time loadable table with two function banks, for example tanh and sigmoid.
- The block does the slope*x+intercept arithmetic itself and uses a valid/ready stream interface with backpressure.
- Sits between an accumulator output and the next layer's input buffer.

---
 rtl/pwl_act_pipe.sv | 151 +++++++++++++++
 tb/tb_pwl_act_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_pipe.sv
// Pipelined piecewise-linear activation: y = slope*|x| (signed by x) + intercept,
// with a two-bank run-time loadable coefficient table and valid/ready flow control.
module pwl_act_pipe #(
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 15,
   parameter int SEG_BITS = 4,
   parameter int STEP_LSB = 13,
   parameter int COEF_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_bank,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   input  logic                  cfg_we,
   input  logic [SEG_BITS+2:0]   cfg_addr,
   input  logic [COEF_W-1:0]     cfg_slope,
   input  logic [DATA_W-1:0]     cfg_icpt,
   output logic                  cfg_err,
   output logic                  busy
);
   localparam int NSEG    = 2**(SEG_BITS+1);
   localparam int NENT    = NSEG + 2;
   localparam int IDX_W   = SEG_BITS + 2;
   localparam int MAG_W   = DATA_W - 1;
   localparam int PROD_W  = MAG_W + COEF_W;
   localparam int SUM_W   = DATA_W + 1;
   localparam logic [IDX_W-1:0] SAT_POS = IDX_W'(NSEG);
   localparam logic [IDX_W-1:0] SAT_NEG = IDX_W'(NSEG + 1);

   logic [COEF_W-1:0] slope_q [2][NENT];
   logic [DATA_W-1:0] icpt_q  [2][NENT];

   logic [2:0]        vld_pipe_q;
   logic              en;
   logic [MAG_W-1:0]  mag1_q;
   logic              sign1_q;
   logic [COEF_W-1:0] slope1_q;
   logic [DATA_W-1:0] icpt1_q;
   logic [DATA_W-1:0] prod2_q;
   logic              sign2_q;
   logic [DATA_W-1:0] icpt2_q;
   logic [DATA_W-1:0] out_data_q;
   logic              cfg_err_q;

   assign en        = !(vld_pipe_q[2] && !out_ready);
   assign in_ready  = en;
   assign out_valid = vld_pipe_q[2];
   assign out_data  = out_data_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (|vld_pipe_q) || in_valid;

   // Table lookup for the sample being offered this cycle
   logic              in_sign;
   logic [MAG_W-1:0]  in_mag;
   logic              ovf;
   logic [IDX_W-1:0]  rd_idx;
   logic [COEF_W-1:0] rd_slope;
   logic [DATA_W-1:0] rd_icpt;

   always_comb begin
      in_sign  = in_data[DATA_W-1];
      in_mag   = in_data[MAG_W-1:0];
      ovf      = |in_mag[MAG_W-1:STEP_LSB+SEG_BITS];
      rd_idx   = ovf ? (in_sign ? SAT_NEG : SAT_POS)
                     : {1'b0, in_sign, in_mag[STEP_LSB+SEG_BITS-1:STEP_LSB]};
      rd_slope = ovf ? '0 : slope_q[in_bank][rd_idx];
      rd_icpt  = icpt_q[in_bank][rd_idx];
   end

   logic              cfg_bank;
   logic [IDX_W-1:0]  cfg_idx;
   logic              cfg_ok;

   always_comb begin
      cfg_bank = cfg_addr[IDX_W];
      cfg_idx  = cfg_addr[IDX_W-1:0];
      cfg_ok   = cfg_we && !busy && (cfg_idx < IDX_W'(NENT));
   end

   // Product magnitude and S3 signed add / sign-magnitude conversion
   logic [PROD_W-1:0] prod_full;
   logic [DATA_W-1:0] prod_d;
   logic [SUM_W-1:0]  p_tc, i_tc, sum, abs_v;
   logic              res_neg;
   logic [MAG_W-1:0]  res_mag;
   logic [DATA_W-1:0] res_d;

   always_comb begin
      prod_full = PROD_W'(mag1_q) * PROD_W'(slope1_q);
      prod_d    = DATA_W'(prod_full >> FRAC_W);
      p_tc      = sign2_q ? -SUM_W'(prod2_q) : SUM_W'(prod2_q);
      i_tc      = icpt2_q[DATA_W-1] ? -SUM_W'(icpt2_q[MAG_W-1:0]) : SUM_W'(icpt2_q[MAG_W-1:0]);
      sum       = p_tc + i_tc;
      res_neg   = sum[SUM_W-1];
      abs_v     = res_neg ? -sum : sum;
      res_mag   = (|abs_v[SUM_W-1:MAG_W]) ? {MAG_W{1'b1}} : abs_v[MAG_W-1:0];
      res_d     = (res_mag == '0) ? '0 : {res_neg, res_mag};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NENT; i++) begin
               slope_q[b][i] <= '0;
               icpt_q[b][i]  <= '0;
            end
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_we && !cfg_ok;
         if (cfg_ok) begin
            slope_q[cfg_bank][cfg_idx] <= cfg_slope;
            icpt_q[cfg_bank][cfg_idx]  <= cfg_icpt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         mag1_q     <= '0;
         sign1_q    <= 1'b0;
         slope1_q   <= '0;
         icpt1_q    <= '0;
         prod2_q    <= '0;
         sign2_q    <= 1'b0;
         icpt2_q    <= '0;
         out_data_q <= '0;
      end else if (en) begin
         vld_pipe_q <= {vld_pipe_q[1:0], in_valid};
         if (in_valid) begin
            mag1_q   <= in_mag;
            sign1_q  <= in_sign;
            slope1_q <= rd_slope;
            icpt1_q  <= rd_icpt;
         end
         if (vld_pipe_q[0]) begin
            prod2_q <= prod_d;
            sign2_q <= sign1_q;
            icpt2_q <= icpt1_q;
         end
         if (vld_pipe_q[1])
            out_data_q <= res_d;
      end
   end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Directed bench for pwl_act_pipe: stimulus pushes expected results into a queue,
// an independent monitor pops and compares whenever a result is handed off.
module tb_pwl_act_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_bank;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        cfg_we;
   logic [6:0]  cfg_addr;
   logic [15:0] cfg_slope;
   logic [31:0] cfg_icpt;
   logic        cfg_err;
   logic        busy;

   pwl_act_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bank(in_bank),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_slope(cfg_slope), .cfg_icpt(cfg_icpt),
      .cfg_err(cfg_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_pop  = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got 0x%08h with nothing expected", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
            n_pop++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 50) begin tick(); t++; end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic cfg_wr(input logic bank, input logic [5:0] idx,
                         input logic [15:0] slope, input logic [31:0] icpt);
      wait_idle();
      cfg_addr  = {bank, idx};
      cfg_slope = slope;
      cfg_icpt  = icpt;
      cfg_we    = 1'b1;
      tick();
      cfg_we    = 1'b0;
      chk("cfg_accept", {31'b0, cfg_err}, 32'd0);
   endtask

   task automatic send(input logic [31:0] d, input logic bank,
                       input logic [31:0] exp, input bit push);
      int t = 0;
      in_data  = d;
      in_bank  = bank;
      in_valid = 1'b1;
      while (!in_ready && t < 50) begin tick(); t++; end
      if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      else begin
         if (push) exp_q.push_back(exp);
         tick();
      end
      in_valid = 1'b0;
   endtask

   logic [31:0] bp_d [5] = '{32'h1000, 32'h0800, 32'h0400, 32'h0200, 32'h0100};
   logic [31:0] bp_e [5] = '{32'h0FAC, 32'h07D6, 32'h03EB, 32'h01F5, 32'h00FA};

   initial begin
      int k, n0, t;
      rst = 1'b1; in_valid = 0; in_data = 0; in_bank = 0; out_ready = 1'b1;
      cfg_we = 0; cfg_addr = 0; cfg_slope = 0; cfg_icpt = 0;
      tick(); tick();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_cfg_err",   {31'b0, cfg_err}, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // positive segment plus latency
      cfg_wr(0, 6'd0, 16'd32101, 32'h0);
      send(32'h0000_1000, 0, 32'h0000_0FAC, 1);
      chk("lat_edge1", {31'b0, out_valid}, 32'd0);
      tick();
      chk("lat_edge2", {31'b0, out_valid}, 32'd0);
      tick();
      chk("lat_edge3", {31'b0, out_valid}, 32'd1);

      // negative segment, saturation, intercept add, bank switching
      cfg_wr(0, 6'd16, 16'd32101, 32'h0);
      send(32'h8000_1000, 0, 32'h8000_0FAC, 1);
      cfg_wr(0, 6'd32, 16'd5, 32'd32768);
      send(32'h0004_0000, 0, 32'h0000_8000, 1);
      send(32'h8004_0000, 0, 32'h0000_0000, 1);
      cfg_wr(1, 6'd1, 16'd28468, 32'd908);
      send(32'h0000_2000, 1, 32'h0000_1F59, 1);
      send(32'h0000_1000, 0, 32'h0000_0FAC, 1);
      send(32'h0000_2000, 1, 32'h0000_1F59, 1);
      send(32'h8000_1000, 0, 32'h8000_0FAC, 1);

      // backpressure: three samples fill the pipe, then the input stalls
      wait_idle();
      out_ready = 1'b0;
      k = 0;
      in_valid = 1'b1;
      in_bank  = 1'b0;
      in_data  = bp_d[0];
      for (int c = 0; c < 6; c++) begin
         if (in_ready) begin
            exp_q.push_back(bp_e[k]);
            k++;
            tick();
            in_data = bp_d[k];
         end else tick();
      end
      chk("bp_accepted", k, 32'd3);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold0", out_data, 32'h0000_0FAC);
      in_valid = 1'b0;
      tick(); tick();
      chk("bp_hold1", out_data, 32'h0000_0FAC);
      n0 = n_pop;
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("bp_drain", n_pop - n0, 32'd3);

      // sign cancellation and clamp
      cfg_wr(0, 6'd17, 16'd32768, 32'h0000_2000);
      send(32'h8000_2000, 0, 32'h0000_0000, 1);
      cfg_wr(0, 6'd15, 16'd65535, 32'h7FFF_FFFF);
      send(32'h0001_E000, 0, 32'h7FFF_FFFF, 1);

      // rejected writes: busy pipeline, invalid index, collision with a sample
      wait_idle();
      send(32'h0000_1000, 0, 32'h0000_0FAC, 1);
      tick();
      cfg_addr = {1'b0, 6'd0}; cfg_slope = 16'd1; cfg_icpt = 32'h0; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("err_busy_pulse", {31'b0, cfg_err}, 32'd1);
      tick();
      chk("err_busy_clear", {31'b0, cfg_err}, 32'd0);
      wait_idle();
      cfg_addr = {1'b0, 6'd34}; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("err_bad_idx", {31'b0, cfg_err}, 32'd1);
      wait_idle();
      cfg_addr = {1'b0, 6'd0}; cfg_slope = 16'd1; cfg_icpt = 32'h0; cfg_we = 1'b1;
      send(32'h0000_1000, 0, 32'h0000_0FAC, 1);
      cfg_we = 1'b0;
      chk("err_collide", {31'b0, cfg_err}, 32'd1);
      wait_idle();
      send(32'h0000_1000, 0, 32'h0000_0FAC, 1);

      // reset with two samples in flight
      wait_idle();
      send(32'h0000_1000, 0, 32'h0, 0);
      send(32'h0000_2000, 1, 32'h0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
         tick();
      end
      chk("post_rst_data", out_data, 32'h0);
      send(32'h0000_1000, 0, 32'h0000_0000, 1);
      send(32'h0000_2000, 1, 32'h0000_0000, 1);

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin tick(); t++; end
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
